// File: rtl/branch_flag_gen_if.sv
// Request/result bundle between the execute stage and the branch-flag comparator.
interface branch_flag_gen_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_cmp;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             flags_valid;
    logic [2:0]       flags;

    // Pipeline side: issues compares and consumes flags.
    modport master (
        output start, signed_cmp, op_a, op_b, flush,
        input  busy, flags_valid, flags
    );

    // Comparator side.
    modport slave (
        input  start, signed_cmp, op_a, op_b, flush,
        output busy, flags_valid, flags
    );
endinterface

// File: rtl/branch_flag_gen.sv
// Multi-cycle magnitude comparator producing one-hot {lt, eq, gt} branch flags.
// Operands are compared CHUNK bits per cycle, MSB chunk first, stopping at the
// first differing chunk. Signed compares flip the sign bits at latch time so the
// chunk datapath only ever does unsigned compares.
module branch_flag_gen #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic               clk,
    input logic               rst,
    branch_flag_gen_if.slave  cmp
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        flags_q, flags_d;
    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic              accept;

    // Chunk currently under comparison.
    assign a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        flags_d = flags_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = cmp.start && !cmp.flush;
            end
            RUN: begin
                if (cmp.flush) begin
                    state_d = IDLE;
                end else if (a_chunk > b_chunk) begin
                    flags_d = 3'b001;
                    state_d = DONE;
                end else if (a_chunk < b_chunk) begin
                    flags_d = 3'b100;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    flags_d = 3'b010;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                // Back-to-back start is allowed unless the cycle is being flushed.
                accept  = cmp.start && !cmp.flush;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Latch operands; flipping the sign bit maps two's complement onto unsigned order.
        if (accept) begin
            a_d            = cmp.op_a;
            b_d            = cmp.op_b;
            a_d[WIDTH-1]   = cmp.op_a[WIDTH-1] ^ cmp.signed_cmp;
            b_d[WIDTH-1]   = cmp.op_b[WIDTH-1] ^ cmp.signed_cmp;
            idx_d          = IDXW'(NCHUNK - 1);
            state_d        = RUN;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        cmp.busy        = (state_q == RUN);
        cmp.flags_valid = (state_q == DONE);
        cmp.flags       = flags_q;
    end
endmodule
